// File: rtl/galaxian_load_pkg.sv
// rtl/galaxian_load_pkg.sv - shared loader states and download index codes
package galaxian_load_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RUN  = 2'd3
  } load_state_t;

  localparam logic [7:0] IDX_ROM = 8'd0;
  localparam logic [7:0] IDX_MOD = 8'd1;
  localparam logic [7:0] IDX_DIP = 8'd254;

  // True when no address bit at or above bit aw is set.
  function automatic logic addr_fits(input logic [24:0] addr, input int aw);
    return (addr >> aw) == 25'd0;
  endfunction

endpackage

// File: rtl/rom_loader_if.sv
// rtl/rom_loader_if.sv - HPS ioctl download bus
interface rom_loader_if;

  logic        ioctl_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_index;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  modport master (
    output ioctl_download,
    output ioctl_wr,
    output ioctl_index,
    output ioctl_addr,
    output ioctl_dout
  );

  modport slave (
    input ioctl_download,
    input ioctl_wr,
    input ioctl_index,
    input ioctl_addr,
    input ioctl_dout
  );

endinterface

// File: rtl/rom_loader.sv
// rtl/rom_loader.sv - routes HPS downloads to core ROM, mod byte and DIP bytes
// and holds the core in reset until a ROM load completes.
module rom_loader
  import galaxian_load_pkg::*;
#(
  parameter int ROM_AW      = 16,
  parameter int HOLD_CYCLES = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  rom_loader_if.slave       ioctl,
  output logic [ROM_AW-1:0] rom_addr,
  output logic [7:0]        rom_data,
  output logic              rom_wr,
  output logic [7:0]        mod_id,
  output logic [63:0]       sw_flat,
  output logic              core_reset,
  output logic              load_done,
  output logic [ROM_AW:0]   byte_count,
  output logic [7:0]        checksum,
  output logic              overflow
);

  localparam int CW = $clog2(HOLD_CYCLES) + 1;
  localparam logic [CW-1:0]   HOLD_INIT = CW'(HOLD_CYCLES - 1);
  localparam logic [ROM_AW:0] COUNT_MAX = {1'b1, {ROM_AW{1'b0}}};

  load_state_t r_state;
  load_state_t w_state_nxt;
  logic [CW-1:0] r_hold_cnt;
  logic [CW-1:0] w_hold_cnt_nxt;

  logic [ROM_AW-1:0] r_rom_addr;
  logic [7:0]        r_rom_data;
  logic              r_rom_wr;
  logic [7:0]        r_mod_id;
  logic [7:0][7:0]   r_sw;
  logic [ROM_AW:0]   r_byte_count;
  logic [7:0]        r_checksum;
  logic              r_overflow;

  logic w_is_rom;
  logic w_rom_strobe;
  logic w_addr_fits;
  logic w_rom_accept;
  logic w_rom_reject;
  logic w_load_entry;
  logic w_mod_wr;
  logic w_dip_wr;

  assign w_is_rom     = (ioctl.ioctl_index == IDX_ROM);
  assign w_addr_fits  = addr_fits(ioctl.ioctl_addr, ROM_AW);
  // Still LOAD in the cycle download falls, so a coincident last byte lands.
  assign w_rom_strobe = ioctl.ioctl_wr && w_is_rom && (r_state == LOAD);
  assign w_rom_accept = w_rom_strobe && w_addr_fits;
  assign w_rom_reject = w_rom_strobe && !w_addr_fits;
  assign w_load_entry = (r_state != LOAD) && (w_state_nxt == LOAD);
  assign w_mod_wr     = ioctl.ioctl_wr && (ioctl.ioctl_index == IDX_MOD)
                        && (ioctl.ioctl_addr == 25'd0);
  assign w_dip_wr     = ioctl.ioctl_wr && (ioctl.ioctl_index == IDX_DIP)
                        && (ioctl.ioctl_addr[24:3] == 22'd0);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    case (r_state)
      IDLE, RUN: begin
        if (ioctl.ioctl_download && w_is_rom) w_state_nxt = LOAD;
      end
      LOAD: begin
        if (!ioctl.ioctl_download) begin
          w_state_nxt    = HOLD;
          w_hold_cnt_nxt = HOLD_INIT;
        end
      end
      HOLD: begin
        if (r_hold_cnt == '0) w_state_nxt = RUN;
        else                  w_hold_cnt_nxt = r_hold_cnt - 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_rom_wr     <= 1'b0;
      r_rom_addr   <= '0;
      r_rom_data   <= '0;
      r_mod_id     <= 8'h00;
      r_sw         <= {8{8'hFF}};
      r_byte_count <= '0;
      r_checksum   <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_rom_wr <= w_rom_accept;
      if (w_rom_accept) begin
        r_rom_addr <= ioctl.ioctl_addr[ROM_AW-1:0];
        r_rom_data <= ioctl.ioctl_dout;
      end
      if (w_load_entry) begin
        r_byte_count <= '0;
        r_checksum   <= '0;
        r_overflow   <= 1'b0;
      end else begin
        if (w_rom_accept) begin
          if (r_byte_count != COUNT_MAX) r_byte_count <= r_byte_count + 1'b1;
          r_checksum <= r_checksum + ioctl.ioctl_dout;
        end
        if (w_rom_reject) r_overflow <= 1'b1;
      end
      if (w_mod_wr) r_mod_id <= ioctl.ioctl_dout;
      if (w_dip_wr) r_sw[ioctl.ioctl_addr[2:0]] <= ioctl.ioctl_dout;
    end
  end

  assign rom_addr   = r_rom_addr;
  assign rom_data   = r_rom_data;
  assign rom_wr     = r_rom_wr;
  assign mod_id     = r_mod_id;
  assign sw_flat    = r_sw;
  assign core_reset = (r_state != RUN);
  assign load_done  = (r_state == RUN);
  assign byte_count = r_byte_count;
  assign checksum   = r_checksum;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_rom_loader.sv
// tb/tb_rom_loader.sv - scoreboard bench for rom_loader
module tb_rom_loader;

  localparam int AW   = 16;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;
  logic          rom_wr;
  logic [7:0]    mod_id;
  logic [63:0]   sw_flat;
  logic          core_reset;
  logic          load_done;
  logic [AW:0]   byte_count;
  logic [7:0]    checksum;
  logic          overflow;

  rom_loader_if io();

  rom_loader #(.ROM_AW(AW), .HOLD_CYCLES(HOLD)) dut (
    .clk_sys    (clk),
    .reset      (reset),
    .ioctl      (io),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rom_wr     (rom_wr),
    .mod_id     (mod_id),
    .sw_flat    (sw_flat),
    .core_reset (core_reset),
    .load_done  (load_done),
    .byte_count (byte_count),
    .checksum   (checksum),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [15:0] a;
    logic [7:0]  d;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rom_wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rom_wr_unexpected", rom_wr, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("rom_wr_cycle", cyc, e.c);
        chk("rom_addr", rom_addr, e.a);
        chk("rom_data", rom_data, e.d);
      end
    end else if (exp_q.size() > 0 && exp_q[0].c < cyc) begin
      chk("rom_wr_missing", rom_wr, 1'b1);
      void'(exp_q.pop_front());
    end
  end

  task automatic strobe(input logic [7:0] idx, input logic [24:0] a,
                        input logic [7:0] d, input bit acc);
    @(posedge clk); #1;
    io.ioctl_wr = 1'b1; io.ioctl_index = idx; io.ioctl_addr = a; io.ioctl_dout = d;
    if (acc) exp_q.push_back('{cyc + 1, a[15:0], d});
    @(posedge clk); #1;
    io.ioctl_wr = 1'b0;
  endtask

  task automatic dl_start(input logic [7:0] idx);
    @(posedge clk); #1;
    io.ioctl_download = 1'b1; io.ioctl_index = idx;
  endtask

  task automatic dl_end(output int fall);
    @(posedge clk); #1;
    io.ioctl_download = 1'b0;
    fall = cyc;
  endtask

  task automatic wait_done(input int fall);
    int n;
    n = 0;
    while (load_done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (load_done !== 1'b1) chk("load_done_timeout", load_done, 1'b1);
    else                    chk("load_done_latency", cyc - fall, HOLD + 1);
  endtask

  task automatic rom4(input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input logic [7:0] b3);
    strobe(8'd0, 25'd0, b0, 1'b1);
    strobe(8'd0, 25'd1, b1, 1'b1);
    strobe(8'd0, 25'd2, b2, 1'b1);
    strobe(8'd0, 25'd3, b3, 1'b1);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_core_reset"}, core_reset, 1'b1);
    chk({tag, "_load_done"}, load_done, 1'b0);
    chk({tag, "_rom_wr"}, rom_wr, 1'b0);
    chk({tag, "_mod_id"}, mod_id, 8'h00);
    chk({tag, "_sw_flat"}, sw_flat, 64'hFFFF_FFFF_FFFF_FFFF);
    chk({tag, "_byte_count"}, byte_count, 0);
    chk({tag, "_checksum"}, checksum, 8'h00);
    chk({tag, "_overflow"}, overflow, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int fall;
    io.ioctl_download = 1'b0; io.ioctl_wr = 1'b0; io.ioctl_index = 8'd0;
    io.ioctl_addr = 25'd0; io.ioctl_dout = 8'd0;

    // Power-on reset
    @(posedge clk); @(negedge clk);
    chk_reset_state("reset");
    chk("reset_rom_addr", rom_addr, 16'h0000);
    chk("reset_rom_data", rom_data, 8'h00);
    @(posedge clk); #1 reset = 1'b0;

    // Four-byte ROM load
    dl_start(8'd0);
    rom4(8'h11, 8'h22, 8'h33, 8'h44);
    dl_end(fall);
    @(negedge clk);
    chk("load_core_reset_hold", core_reset, 1'b1);
    wait_done(fall);
    chk("load4_byte_count", byte_count, 4);
    chk("load4_checksum", checksum, 8'hAA);
    chk("load4_core_reset", core_reset, 1'b0);

    // Mod byte in RUN; off-address mod byte ignored
    strobe(8'd1, 25'd0, 8'h0C, 1'b0);
    strobe(8'd1, 25'd1, 8'h77, 1'b0);
    @(negedge clk);
    chk("mod_id", mod_id, 8'h0C);
    chk("mod_run_kept", load_done, 1'b1);
    chk("mod_core_reset", core_reset, 1'b0);

    // DIP bytes; address 8 is out of range
    dl_start(8'd254);
    strobe(8'd254, 25'd2, 8'h0F, 1'b0);
    strobe(8'd254, 25'd8, 8'h55, 1'b0);
    dl_end(fall);
    @(negedge clk);
    chk("dip_sw_flat", sw_flat, 64'hFFFF_FFFF_FF0F_FFFF);
    chk("dip_run_kept", load_done, 1'b1);

    // Out-of-range ROM byte and top in-range address
    dl_start(8'd0);
    strobe(8'd0, 25'h0000000, 8'h99, 1'b1);
    strobe(8'd0, 25'h0010000, 8'h5A, 1'b0);
    strobe(8'd0, 25'h000FFFF, 8'h01, 1'b1);
    @(negedge clk);
    chk("ovf_flag", overflow, 1'b1);
    chk("ovf_byte_count", byte_count, 2);
    chk("ovf_checksum", checksum, 8'h9A);
    dl_end(fall);
    wait_done(fall);

    // ROM strobe in RUN with download low is ignored
    strobe(8'd0, 25'd5, 8'h77, 1'b0);
    @(negedge clk);
    chk("run_strobe_count", byte_count, 2);
    chk("run_strobe_checksum", checksum, 8'h9A);
    chk("run_strobe_state", load_done, 1'b1);

    // Strobe coincident with download fall
    dl_start(8'd0);
    strobe(8'd0, 25'd0, 8'h01, 1'b1);
    @(posedge clk); #1;
    io.ioctl_wr = 1'b1; io.ioctl_index = 8'd0; io.ioctl_addr = 25'd1; io.ioctl_dout = 8'h02;
    io.ioctl_download = 1'b0;
    fall = cyc;
    exp_q.push_back('{cyc + 1, 16'h0001, 8'h02});
    @(posedge clk); #1 io.ioctl_wr = 1'b0;
    @(negedge clk);
    chk("fall_byte_count", byte_count, 2);
    chk("fall_checksum", checksum, 8'h03);
    chk("fall_overflow_cleared", overflow, 1'b0);
    chk("fall_in_hold_core_reset", core_reset, 1'b1);
    chk("fall_in_hold_load_done", load_done, 1'b0);
    wait_done(fall);

    // Reset after two of four bytes
    dl_start(8'd0);
    strobe(8'd0, 25'd0, 8'h11, 1'b1);
    strobe(8'd0, 25'd1, 8'h22, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1; io.ioctl_download = 1'b0;
    @(posedge clk); @(negedge clk);
    chk_reset_state("midload");
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("after_reset_stays_idle", load_done, 1'b0);
    dl_start(8'd0);
    rom4(8'h11, 8'h22, 8'h33, 8'h44);
    dl_end(fall);
    wait_done(fall);
    chk("reload_byte_count", byte_count, 4);
    chk("reload_checksum", checksum, 8'hAA);

    // Empty ROM download
    dl_start(8'd0);
    dl_end(fall);
    wait_done(fall);
    chk("empty_byte_count", byte_count, 0);
    chk("empty_checksum", checksum, 8'h00);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 Parameter ROM_AW, default 16, ROM address width forwarded to the core.
REQ-002 Parameter HOLD_CYCLES, default 16, core-reset hold length after download ends.
REQ-003 clk_sys  in  1  system clock; the only clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ioctl_download  in  1  HPS download in progress.
REQ-006 ioctl_wr  in  1  download byte strobe, one cycle.
REQ-007 ioctl_index  in  8  download target: 0 = ROM, 1 = mod byte, 254 = DIP bytes.
REQ-008 ioctl_addr  in  25  byte address within the download.
REQ-009 ioctl_dout  in  8  download byte.
REQ-010 rom_addr  out  ROM_AW  ROM write address to the core.
REQ-011 rom_data  out  8  ROM write data to the core.
REQ-012 rom_wr  out  1  ROM write strobe, one cycle.
REQ-013 mod_id  out  8  game selector byte.
REQ-014 sw_flat  out  64  DIP bytes; sw[n] occupies bits 8n+7:8n.
REQ-015 core_reset  out  1  reset request to the core.
REQ-016 load_done  out  1  ROM load completed; core running.
REQ-017 byte_count  out  ROM_AW+1  accepted ROM bytes in the last or current load.
REQ-018 checksum  out  8  mod-256 sum of accepted ROM bytes.
REQ-019 overflow  out  1  sticky: a ROM byte arrived with address at or above 2^ROM_AW.

Function
REQ-020 States: IDLE, LOAD, HOLD, RUN.
- IDLE: core_reset = 1, load_done = 0.
- LOAD: core_reset = 1, load_done = 0.
- HOLD: core_reset = 1, load_done = 0.
- RUN: core_reset = 0, load_done = 1.
REQ-021 IDLE or RUN -> LOAD on the first cycle with ioctl_download = 1 and ioctl_index = 0. On that entry, byte_count, checksum and overflow clear.
REQ-022 LOAD -> HOLD on the first cycle with ioctl_download = 0. The hold counter loads HOLD_CYCLES-1.
REQ-023 HOLD decrements the counter every cycle and goes to RUN in the cycle after the counter reads 0. HOLD therefore lasts exactly HOLD_CYCLES cycles.
REQ-024 A ROM byte is accepted when ioctl_wr = 1, ioctl_index = 0, state = LOAD, and ioctl_addr[24:ROM_AW] = 0.
REQ-025 For an accepted byte, the registered rom_addr = ioctl_addr[ROM_AW-1:0], rom_data = ioctl_dout, and rom_wr = 1 exactly one cycle after the strobe. rom_wr is 0 otherwise.
REQ-026 Each accepted byte increments byte_count, saturating at 2^ROM_AW, and adds ioctl_dout to checksum mod 256. Both update in the same cycle as rom_wr.
REQ-027 An out-of-range ROM byte (index 0, ioctl_addr[24:ROM_AW] != 0) sets overflow, produces no rom_wr and does not change byte_count or checksum.
REQ-028 ioctl_wr with index 1 and ioctl_addr = 0 loads mod_id in any state. Index-1 bytes at other addresses are ignored.
REQ-029 ioctl_wr with index 254 and ioctl_addr[24:3] = 0 loads sw[ioctl_addr[2:0]] in any state.
REQ-030 Downloads with index other than 0 never change the state.
REQ-031 A strobe in the same cycle that ioctl_download falls is still accepted, provided index = 0. The state moves to HOLD in that same cycle.
REQ-032 An empty ROM download passes LOAD -> HOLD -> RUN with byte_count = 0 and checksum = 0.
REQ-033 A ROM strobe in IDLE, HOLD or RUN (download low) is ignored.

Reset
REQ-034 reset forces, on the next clock edge:
- state = IDLE
- core_reset = 1, load_done = 0
- rom_wr = 0, rom_addr = 0, rom_data = 0
- mod_id = 0x00
- every sw byte = 0xFF
- byte_count = 0, checksum = 0, overflow = 0
- hold counter = 0
REQ-035 Reset asserted mid-LOAD aborts the load. A new rising download with index 0 is required to reach RUN.
REQ-036 reset has priority over every strobe in the same cycle.

Structure
REQ-037 The shared package galaxian_load_pkg holds:
- the state enum load_state_t {IDLE, LOAD, HOLD, RUN}
- constants IDX_ROM = 0, IDX_MOD = 1, IDX_DIP = 254
REQ-038 The block is a single module with no sub-modules. The hold counter is internal and $clog2(HOLD_CYCLES)+1 bits wide.

Verification
REQ-039 Reset, then download index 0 with 4 bytes 0x11, 0x22, 0x33, 0x44 at addresses 0-3.
- Four rom_wr pulses, each one cycle after its strobe.
- byte_count = 4, checksum = 0xAA.
- load_done rises exactly HOLD_CYCLES+1 cycles after download falls.
REQ-040 Index-0 byte at address 0x10000 -> no rom_wr, overflow = 1, byte_count unchanged.
REQ-041 Index 254 with bytes 0x0F at address 2 and 0x55 at address 8.
- sw_flat[23:16] = 0x0F.
- The address-8 byte is ignored.
- All other sw bytes remain 0xFF.
REQ-042 Index 1 with byte 0x0C at address 0 during RUN.
- mod_id = 0x0C.
- State stays RUN and core_reset stays 0.
REQ-043 Reset asserted after 2 of 4 ROM bytes.
- Next cycle: IDLE, byte_count = 0, core_reset = 1.
- A later full download reaches RUN with byte_count = 4.
REQ-044 Strobe coincident with the download falling edge -> byte accepted, byte_count includes it, state = HOLD.
